reg_ascii_fmt: RTL

- Parametrised sequential formatter. Converts NCH register snapshots of W bits each into a packed ASCII character buffer for the LCD text driver.
- Each channel is rendered in decimal (full range, serial double-dabble) or hex, selected per channel.
- Sits between the datapath debug taps (state, $regs, PC, MDR, ALUOut) and the LCD character interface.
- Replaces fixed two-digit combinational conversion, which truncates values of 100 and above.

---
 rtl/reg_ascii_pkg.sv | 29 ++
 rtl/dd_bcd_serial.sv | 38 +++
 rtl/reg_ascii_fmt.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/reg_ascii_pkg.sv
// Shared definitions for the register-to-ASCII formatter: FSM encoding,
// ASCII constants and the nibble helpers used by the converter.
package reg_ascii_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      WRITE,
      DONE
   } state_t;

   localparam logic [7:0] SPACE   = 8'h20;
   localparam logic [7:0] ZERO    = 8'h30;
   localparam logic [7:0] UPPER_A = 8'h41;

   function automatic logic [7:0] hex2ascii(input logic [3:0] v);
      if (v < 4'd10)
         return ZERO + {4'd0, v};
      else
         return UPPER_A + {4'd0, v} - 8'd10;
   endfunction

   // Double-dabble correction: a digit >= 5 would carry past 9 after the shift.
   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

endpackage

// File: rtl/dd_bcd_serial.sv
// Serial shift/add-3 binary-to-BCD engine: load captures din and clears the
// accumulator, each shift cycle corrects nibbles then shifts {bcd, shreg} left.
module dd_bcd_serial
   import reg_ascii_pkg::*;
#(
   parameter int W  = 8,
   parameter int FD = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            shift,
   input  logic [W-1:0]    din,
   output logic [4*FD-1:0] bcd
);

   logic [W-1:0]    shreg;
   logic [4*FD-1:0] adj;

   always_comb begin
      adj = '0;
      for (int i = 0; i < FD; i++)
         adj[4*i +: 4] = add3(bcd[4*i +: 4]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg <= '0;
         bcd   <= '0;
      end else if (load) begin
         shreg <= din;
         bcd   <= '0;
      end else if (shift) begin
         {bcd, shreg} <= {adj, shreg} << 1;
      end
   end

endmodule

// File: rtl/reg_ascii_fmt.sv
// Sequential formatter of NCH register snapshots into a packed ASCII buffer,
// decimal or hex per channel. Optional macro REG_ASCII_FMT_ZBLANK_EN blanks leading decimal zeros.
module reg_ascii_fmt
   import reg_ascii_pkg::*;
#(
   parameter int NCH = 8,
   parameter int W   = 8,
   parameter int FD  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [NCH*W-1:0]      data,
   input  logic [NCH-1:0]        hex_mode,
   output logic                  busy,
   output logic                  done,
   output logic [NCH*FD*8-1:0]   chars
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = $clog2(W + 1);
   localparam int HD = W / 4;

   generate
      if (FD < W / 4 || (64'd10 ** FD) <= ((64'd1 << W) - 64'd1)) begin : g_bad_fd
         $error("reg_ascii_fmt: FD too small for W");
      end
   endgenerate

   state_t            state, nstate;
   logic [NCH*W-1:0]  snap_data;
   logic [NCH-1:0]    snap_hex;
   logic [IW-1:0]     idx;
   logic [CW-1:0]     cnt;
   logic [W-1:0]      cur_val;
   logic              cur_hex;
   logic [4*FD-1:0]   bcd;
   logic [FD*8-1:0]   field;
   logic              ld, sh, wr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   always_comb begin
      nstate = state;
      ld     = 1'b0;
      sh     = 1'b0;
      wr     = 1'b0;
      busy   = (state != IDLE);
      done   = (state == DONE);
      case (state)
         IDLE:    if (start) nstate = LOAD;
         LOAD: begin
            ld     = 1'b1;
            nstate = SHIFT;
         end
         SHIFT: begin
            sh = 1'b1;
            if (cnt == CW'(W - 1)) nstate = WRITE;
         end
         WRITE: begin
            wr     = 1'b1;
            nstate = (idx == IW'(NCH - 1)) ? DONE : LOAD;
         end
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // hex_mode bit c selects the format of channel c; data channel 0 sits in the MSBs.
   always_comb begin
      cur_val = '0;
      cur_hex = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (idx == IW'(c)) begin
            cur_val = snap_data[(NCH-1-c)*W +: W];
            cur_hex = snap_hex[c];
         end
      end
   end

   dd_bcd_serial #(.W(W), .FD(FD)) u_dd (
      .clk   (clk),
      .reset (reset),
      .load  (ld),
      .shift (sh),
      .din   (cur_val),
      .bcd   (bcd)
   );

`ifdef REG_ASCII_FMT_ZBLANK_EN
   logic lead;
`endif
   logic [3:0]      dig;
   logic [4*HD-1:0] hv;

   always_comb begin
      field = {FD{SPACE}};
      dig   = '0;
      hv    = cur_val[4*HD-1:0];
`ifdef REG_ASCII_FMT_ZBLANK_EN
      lead  = 1'b1;
`endif
      if (cur_hex) begin
         for (int i = 0; i < HD; i++)
            field[8*i +: 8] = hex2ascii(hv[4*i +: 4]);
      end else begin
         for (int i = FD - 1; i >= 0; i--) begin
            dig = bcd[4*i +: 4];
`ifdef REG_ASCII_FMT_ZBLANK_EN
            if (lead && dig == 4'd0 && i != 0) begin
               field[8*i +: 8] = SPACE;
            end else begin
               lead            = 1'b0;
               field[8*i +: 8] = ZERO + {4'd0, dig};
            end
`else
            field[8*i +: 8] = ZERO + {4'd0, dig};
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_data <= '0;
         snap_hex  <= '0;
         idx       <= '0;
         cnt       <= '0;
         chars     <= {(NCH*FD){SPACE}};
      end else begin
         if (state == IDLE && start) begin
            snap_data <= data;
            snap_hex  <= hex_mode;
            idx       <= '0;
         end
         if (ld)      cnt <= '0;
         else if (sh) cnt <= cnt + CW'(1);
         if (wr && idx != IW'(NCH - 1)) idx <= idx + IW'(1);
         for (int c = 0; c < NCH; c++) begin
            if (wr && idx == IW'(c))
               chars[(NCH-1-c)*FD*8 +: FD*8] <= field;
         end
      end
   end

endmodule
